imem_loader: RTL and testbench

Boot-time instruction loader that sits in front of the pipelined CPU. After reset it zero-fills instruction memory, then receives a byte stream (16-bit word count followed by little-endian 32-bit instruction words), writes the words to consecutive instruction-memory addresses from 0, and finally raises `start_o`, which drives the CPU's `start_i`. It replaces the bench-side memory preload with a synthesizable path.

---
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader.sv | 169 ++++++++++++++++
 tb/tb_imem_loader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Boot-loader bus bundle: the incoming byte stream plus the instruction-memory write port.
// The loader uses the slave view; whoever feeds bytes and owns the memory uses the master view.
interface imem_loader_if #(
    parameter int AW = 8
) ();
    logic          byte_valid_i;
    logic [7:0]    byte_i;
    logic          byte_ready_o;
    logic          imem_we_o;
    logic [AW-1:0] imem_addr_o;
    logic [31:0]   imem_data_o;

    modport slave (
        input  byte_valid_i,
        input  byte_i,
        output byte_ready_o,
        output imem_we_o,
        output imem_addr_o,
        output imem_data_o
    );

    modport master (
        output byte_valid_i,
        output byte_i,
        input  byte_ready_o,
        input  imem_we_o,
        input  imem_addr_o,
        input  imem_data_o
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction loader: zero-fills instruction memory, then copies a length-prefixed
// little-endian word stream into it from address 0 and releases the CPU with a sticky start.
module imem_loader #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    imem_loader_if.slave    bus,
    output logic            start_o,
    output logic            error_o,
    output logic [AW:0]     words_o
);
    typedef enum logic [2:0] {
        S_CLEAR, S_HDR_LO, S_HDR_HI, S_DATA, S_DONE, S_ERROR
    } state_t;

    localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [15:0] DEPTH_16 = 16'(DEPTH);

    state_t        r_state, w_state;
    logic [AW:0]   r_clr, w_clr;
    logic [15:0]   r_count, w_count;
    logic [1:0]    r_lane, w_lane;
    logic [23:0]   r_asm, w_asm;
    logic          r_we, w_we;
    logic [AW-1:0] r_addr, w_addr;
    logic [31:0]   r_data, w_data;
    logic [AW:0]   r_words, w_words;
    logic          r_start, w_start;
    logic          r_error, w_error;
    logic          r_ready, w_ready;

    logic          w_accept;
    logic [15:0]   w_hdr;
    logic [AW:0]   w_words_inc;

    assign w_accept    = bus.byte_valid_i && r_ready;
    assign w_hdr       = {bus.byte_i, r_count[7:0]};
    assign w_words_inc = r_words + {{AW{1'b0}}, 1'b1};

    // Next-state and next-output computation for every loader phase.
    always_comb begin
        w_state = r_state;
        w_clr   = r_clr;
        w_count = r_count;
        w_lane  = r_lane;
        w_asm   = r_asm;
        w_we    = 1'b0;
        w_addr  = r_addr;
        w_data  = r_data;
        w_words = r_words;
        w_start = r_start;
        w_error = r_error;
        case (r_state)
            S_CLEAR: begin
                // r_clr runs one past the last address so the final zero write is not cut short
                if (r_clr == DEPTH_W) begin
                    w_state = S_HDR_LO;
                end else begin
                    w_we   = 1'b1;
                    w_addr = r_clr[AW-1:0];
                    w_data = 32'h0000_0000;
                    w_clr  = r_clr + {{AW{1'b0}}, 1'b1};
                end
            end
            S_HDR_LO: begin
                if (w_accept) begin
                    w_count = {8'h00, bus.byte_i};
                    w_state = S_HDR_HI;
                end else begin
                    w_state = S_HDR_LO;
                end
            end
            S_HDR_HI: begin
                if (w_accept) begin
                    w_count = w_hdr;
                    w_lane  = 2'd0;
                    if (w_hdr == 16'h0000) begin
                        w_state = S_DONE;
                        w_start = 1'b1;
                    end else if (w_hdr > DEPTH_16) begin
                        w_state = S_ERROR;
                        w_error = 1'b1;
                    end else begin
                        w_state = S_DATA;
                    end
                end else begin
                    w_state = S_HDR_HI;
                end
            end
            S_DATA: begin
                if (w_accept && (r_lane == 2'd3)) begin
                    w_we    = 1'b1;
                    w_addr  = r_words[AW-1:0];
                    w_data  = {bus.byte_i, r_asm};
                    w_words = w_words_inc;
                    w_lane  = 2'd0;
                    w_asm   = 24'h00_0000;
                    if (16'(w_words_inc) == r_count) begin
                        w_state = S_DONE;
                    end else begin
                        w_state = S_DATA;
                    end
                end else if (w_accept) begin
                    w_lane = r_lane + 2'd1;
                    case (r_lane)
                        2'd0:    w_asm[7:0]   = bus.byte_i;
                        2'd1:    w_asm[15:8]  = bus.byte_i;
                        2'd2:    w_asm[23:16] = bus.byte_i;
                        default: w_asm        = r_asm;
                    endcase
                end else begin
                    w_lane = r_lane;
                end
            end
            S_DONE:  w_start = 1'b1;
            S_ERROR: w_error = 1'b1;
            default: w_state = S_CLEAR;
        endcase
        w_ready = (w_state == S_HDR_LO) || (w_state == S_HDR_HI) || (w_state == S_DATA);
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state;
        end
    end

    // Counters, word assembly and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_clr   <= '0;
            r_count <= 16'h0000;
            r_lane  <= 2'd0;
            r_asm   <= 24'h00_0000;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= 32'h0000_0000;
            r_words <= '0;
            r_start <= 1'b0;
            r_error <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_clr   <= w_clr;
            r_count <= w_count;
            r_lane  <= w_lane;
            r_asm   <= w_asm;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_words <= w_words;
            r_start <= w_start;
            r_error <= w_error;
            r_ready <= w_ready;
        end
    end

    assign bus.byte_ready_o = r_ready;
    assign bus.imem_we_o    = r_we;
    assign bus.imem_addr_o  = r_addr;
    assign bus.imem_data_o  = r_data;
    assign start_o          = r_start;
    assign error_o          = r_error;
    assign words_o          = r_words;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random byte streams checked against a stream-level
// model of the expected memory image, write timing, start/error timing and word count.
module tb_imem_loader;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start;
    logic        error;
    logic [AW:0] words;

    imem_loader_if #(.AW(AW)) bus ();

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus),
        .start_o (start),
        .error_o (error),
        .words_o (words)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];
    int            ws_q[$];
    int            start_cyc = -1;
    int            err_cyc   = -1;

    logic [7:0]    stream_q[$];
    int            acc_q[$];

    // Write/start/error log, stamped with the clock edge that produced each event.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            wa_q.delete();
            wd_q.delete();
            ws_q.delete();
            start_cyc <= -1;
            err_cyc   <= -1;
        end else begin
            if (bus.imem_we_o === 1'b1) begin
                wa_q.push_back(bus.imem_addr_o);
                wd_q.push_back(bus.imem_data_o);
                ws_q.push_back(cyc);
            end
            if (start === 1'b1 && start_cyc < 0) start_cyc <= cyc;
            if (error === 1'b1 && err_cyc < 0) err_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, longint'(bus.imem_we_o), 0);
        chk({tag, "_ready"}, longint'(bus.byte_ready_o), 0);
        chk({tag, "_addr"}, longint'(bus.imem_addr_o), 0);
        chk({tag, "_data"}, longint'(bus.imem_data_o), 0);
        chk({tag, "_start"}, longint'(start), 0);
        chk({tag, "_error"}, longint'(error), 0);
        chk({tag, "_words"}, longint'(words), 0);
    endtask

    task automatic wait_clear(input int rel);
        int n = 0;
        int bad = 0;
        while (bus.byte_ready_o !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        chk("clear_bounded", longint'(n < 400), 1);
        chk("clear_nwrites", longint'(wa_q.size()), DEPTH);
        for (int i = 0; i < wa_q.size(); i++) begin
            if (wa_q[i] !== AW'(i) || wd_q[i] !== 32'h0 || ws_q[i] !== rel + 1 + i) bad++;
        end
        chk("clear_pattern", longint'(bad), 0);
        chk("clear_ready_cycle", longint'(cyc), longint'(rel + 1 + DEPTH));
        chk("clear_no_start", longint'(start_cyc), -1);
        chk("clear_words", longint'(words), 0);
    endtask

    task automatic do_reset();
        bus.byte_valid_i = 1'b0;
        bus.byte_i       = 8'h00;
        rst_n            = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        wait_clear(cyc);
    endtask

    // Stream of header + random words (data omitted when the header is illegal) + extra bytes.
    task automatic make_stream(input int count, input int extra);
        stream_q.delete();
        stream_q.push_back(8'(count));
        stream_q.push_back(8'(count >> 8));
        if (count <= DEPTH) begin
            for (int i = 0; i < 4 * count; i++) stream_q.push_back(8'($urandom));
        end
        for (int i = 0; i < extra; i++) stream_q.push_back(8'($urandom));
    endtask

    task automatic send_stream(input int gap_lo, input int gap_hi);
        acc_q.delete();
        for (int i = 0; i < stream_q.size(); i++) begin
            int gap = int'($urandom_range(gap_hi, gap_lo));
            int n = 0;
            repeat (gap) step();
            bus.byte_valid_i = 1'b1;
            bus.byte_i       = stream_q[i];
            while (bus.byte_ready_o !== 1'b1 && n < 8) begin
                step();
                n++;
            end
            if (bus.byte_ready_o === 1'b1) begin
                step();
                acc_q.push_back(cyc);
            end else begin
                acc_q.push_back(-1);
            end
            bus.byte_valid_i = 1'b0;
        end
        repeat (4) step();
    endtask

    // Reference: memory image and event timing derived from the byte stream alone.
    task automatic check_stream(input string tag, input int base);
        int count = int'({stream_q[1], stream_q[0]});
        int nw    = (count > DEPTH) ? 0 : count;
        int bad   = 0;
        chk({tag, "_nwrites"}, longint'(wa_q.size() - base), longint'(nw));
        for (int w = 0; w < nw; w++) begin
            logic [31:0] ed = {stream_q[5+4*w], stream_q[4+4*w], stream_q[3+4*w], stream_q[2+4*w]};
            int idx = base + w;
            if (idx >= wa_q.size()) bad++;
            else if (wa_q[idx] !== AW'(w) || wd_q[idx] !== ed || ws_q[idx] !== acc_q[5+4*w]) bad++;
        end
        chk({tag, "_image"}, longint'(bad), 0);
        chk({tag, "_words"}, longint'(words), longint'(nw));
        chk({tag, "_error"}, longint'(error), longint'(count > DEPTH));
        chk({tag, "_start"}, longint'(start), longint'(count <= DEPTH));
        if (count > DEPTH) begin
            chk({tag, "_err_cycle"}, longint'(err_cyc), longint'(acc_q[1]));
            chk({tag, "_start_cycle"}, longint'(start_cyc), -1);
        end else begin
            chk({tag, "_start_cycle"}, longint'(start_cyc),
                longint'((count == 0) ? acc_q[1] : acc_q[1+4*count] + 1));
        end
        chk({tag, "_ready_low"}, longint'(bus.byte_ready_o), 0);
    endtask

    initial begin
        int base;
        bus.byte_valid_i = 1'b0;
        bus.byte_i       = 8'h00;

        // Reset, idle input, full clear sweep.
        do_reset();

        // Two-word example stream, back-to-back.
        stream_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'hB3, 8'h02, 8'hA0, 8'h00};
        base = wa_q.size();
        send_stream(0, 0);
        check_stream("two_words", base);
        chk("two_words_w0", longint'(wd_q[base]), 64'h0050_0013);
        chk("two_words_w1", longint'(wd_q[base+1]), 64'h00A0_02B3);

        // Empty program.
        do_reset();
        make_stream(0, 2);
        base = wa_q.size();
        send_stream(0, 1);
        check_stream("empty", base);

        // Header larger than memory, trailing bytes must be ignored.
        do_reset();
        make_stream(301, 3);
        base = wa_q.size();
        send_stream(0, 0);
        check_stream("too_big", base);

        // Smallest illegal count.
        do_reset();
        make_stream(DEPTH + 1, 1);
        base = wa_q.size();
        send_stream(0, 0);
        check_stream("depth_plus1", base);

        // Single word with three idle cycles before every byte.
        do_reset();
        make_stream(1, 0);
        base = wa_q.size();
        send_stream(3, 3);
        check_stream("gapped_one", base);

        // Reset mid-word: partial word must never reach memory.
        do_reset();
        stream_q = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        send_stream(0, 0);
        chk("mid_ready_before", longint'(bus.byte_ready_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        step();
        rst_n = 1'b1;
        wait_clear(cyc);

        // Random programs with random gaps.
        for (int t = 0; t < 4; t++) begin
            do_reset();
            make_stream(int'($urandom_range(6, 1)), int'($urandom_range(2, 0)));
            base = wa_q.size();
            send_stream(0, 2);
            check_stream("random", base);
        end

        // Full-depth program.
        do_reset();
        make_stream(DEPTH, 1);
        base = wa_q.size();
        send_stream(0, 0);
        check_stream("full_depth", base);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
